// File: rtl/flash_unlock_pkg.sv
// Shared constants for the PRG flash write-unlock block: state encoding,
// register addresses in the $5xxx window, relock command and status layout.
// Pure definitions; no logic, no latency, no flow control.
package flash_unlock_pkg;

    // Lock FSM encoding (2 bits, visible on lock_state and in the status byte)
    localparam logic [1:0] ST_LOCKED   = 2'd0;
    localparam logic [1:0] ST_KEY1_OK  = 2'd1;
    localparam logic [1:0] ST_KEY2_OK  = 2'd2;
    localparam logic [1:0] ST_UNLOCKED = 2'd3;

    // Register addresses as seen on CPU A14..A0 with /ROMSEL high
    localparam logic [14:0] KEYREG_ADDR  = 15'h5FF0;
    localparam logic [14:0] STATREG_ADDR = 15'h5FF1;

    // Key register value that forces an immediate relock while unlocked
    localparam logic [7:0] RELOCK_CMD = 8'h00;

    // Status byte layout: {state[1:0], budget_zero, 0, violation[3:0]}
    localparam int STAT_STATE_LSB = 6;
    localparam int STAT_BZERO_BIT = 5;
    localparam int STAT_VIOL_LSB  = 0;

    function automatic logic [7:0] pack_status(input logic [1:0] st,
                                               input logic       bzero,
                                               input logic [3:0] viol);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_STATE_LSB +: 2] = st;
        s[STAT_BZERO_BIT]      = bzero;
        s[STAT_VIOL_LSB +: 4]  = viol;
        return s;
    endfunction

endpackage

// File: rtl/m2_timeout_counter.sv
// Saturating up-counter on the falling edge of M2 with clear, enable and a limit.
// hit_o is combinational: high when the enabled increment on this edge reaches limit_i.
// No backpressure; counter holds at limit_i once there.
module m2_timeout_counter #(
    parameter int WIDTH = 8
) (
    input  logic             m2_i,
    input  logic             reset_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             hit_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Terminal flag asserted on the edge whose increment lands on the limit
    assign hit_o = en_i && !clr_i && (cnt_q >= (limit_i - WIDTH'(1)));

    // Count register, updated at the end of each CPU cycle
    always_ff @(negedge m2_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flash_write_unlock.sv
// Gates PRG flash writes behind a 3-byte key written to $5FF0, with auto-relock.
// State and prg_write_enabled update on the falling M2 edge closing the key/ROM write.
// No backpressure; CPU bus is sampled every cycle, status readback is combinational.
module flash_write_unlock
    import flash_unlock_pkg::*;
#(
    parameter logic [7:0] KEY0         = 8'hC0,
    parameter logic [7:0] KEY1         = 8'h01,
    parameter logic [7:0] KEY2         = 8'h6E,
    parameter int         KEY_TIMEOUT  = 64,
    parameter int         IDLE_TIMEOUT = 1789773,
    parameter int         WRITE_BUDGET = 512
) (
    input  logic        m2,
    input  logic        reset_n,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic        prg_write_enabled,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_out_enabled,
    output logic [1:0]  lock_state
);

    localparam int TMO_MAX = (KEY_TIMEOUT > IDLE_TIMEOUT) ? KEY_TIMEOUT : IDLE_TIMEOUT;
    localparam int TW      = $clog2(TMO_MAX + 1);
    localparam int BW      = $clog2(WRITE_BUDGET + 1);

    localparam logic [TW-1:0] KEY_LIMIT   = TW'(KEY_TIMEOUT);
    localparam logic [TW-1:0] IDLE_LIMIT  = TW'(IDLE_TIMEOUT);
    localparam logic [BW-1:0] BUDGET_FULL = BW'(WRITE_BUDGET);

    logic [1:0]    state_q,  state_d;
    logic [BW-1:0] budget_q, budget_d;
    logic [3:0]    viol_q,   viol_d;
    logic          pwe_q;

    logic          keyreg_sel, statreg_sel;
    logic          key_wr, stat_wr, romwr;
    logic          tmo_clr, tmo_en, tmo_hit;
    logic [TW-1:0] tmo_limit;

    // Bus decode; key/status registers need /ROMSEL high, ROM writes need it low
    assign keyreg_sel  = romsel && (cpu_addr_in == KEYREG_ADDR);
    assign statreg_sel = romsel && (cpu_addr_in == STATREG_ADDR);
    assign key_wr      = keyreg_sel && !cpu_rw_in;
    assign stat_wr     = statreg_sel && !cpu_rw_in;
    assign romwr       = !romsel && !cpu_rw_in;

    // One counter serves both timeouts: key spacing in KEY1/KEY2, idle time in UNLOCKED
    m2_timeout_counter #(
        .WIDTH (TW)
    ) u_tmo (
        .m2_i      (m2),
        .reset_n_i (reset_n),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .limit_i   (tmo_limit),
        .hit_o     (tmo_hit)
    );

    // Lock FSM, write budget and timeout-counter control
    always_comb begin
        state_d   = state_q;
        budget_d  = budget_q;
        tmo_clr   = 1'b1;
        tmo_en    = 1'b0;
        tmo_limit = KEY_LIMIT;
        case (state_q)
            ST_LOCKED: begin
                if (key_wr && (cpu_data_in == KEY0)) begin
                    state_d = ST_KEY1_OK;
                end
            end
            ST_KEY1_OK: begin
                tmo_clr = key_wr;
                tmo_en  = !key_wr;
                if (key_wr) begin
                    state_d = (cpu_data_in == KEY1) ? ST_KEY2_OK : ST_LOCKED;
                end else if (romwr || tmo_hit) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_KEY2_OK: begin
                tmo_clr = key_wr;
                tmo_en  = !key_wr;
                if (key_wr) begin
                    if (cpu_data_in == KEY2) begin
                        state_d  = ST_UNLOCKED;
                        budget_d = BUDGET_FULL;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else if (romwr || tmo_hit) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                tmo_limit = IDLE_LIMIT;
                tmo_clr   = romwr;
                tmo_en    = !romwr;
                if (romwr) begin
                    // The last budgeted write still completes: enable stays high this cycle
                    if (budget_q != '0) begin
                        budget_d = budget_q - BW'(1);
                    end
                    if (budget_q <= BW'(1)) begin
                        state_d = ST_LOCKED;
                    end
                end else if (key_wr && (cpu_data_in == RELOCK_CMD)) begin
                    state_d = ST_LOCKED;
                end else if (tmo_hit) begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    // Violation counter: ROM writes while not unlocked, saturating; status write clears
    always_comb begin
        viol_d = viol_q;
        if (stat_wr) begin
            viol_d = 4'h0;
        end else if (romwr && (state_q != ST_UNLOCKED) && (viol_q != 4'hF)) begin
            viol_d = viol_q + 4'h1;
        end
    end

    // State registers on the falling M2 edge; write enable tracks the next state
    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_LOCKED;
            budget_q <= BUDGET_FULL;
            viol_q   <= 4'h0;
            pwe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            budget_q <= budget_d;
            viol_q   <= viol_d;
            pwe_q    <= (state_d == ST_UNLOCKED);
        end
    end

    assign prg_write_enabled    = pwe_q;
    assign lock_state           = state_q;
    assign cpu_data_out         = pack_status(state_q, (budget_q == '0), viol_q);
    assign cpu_data_out_enabled = m2 && cpu_rw_in && statreg_sel;

endmodule

// File: tb/tb_flash_write_unlock.sv
// Directed bench for flash_write_unlock with a small write budget and idle timeout.
// Inputs change on the rising M2 edge; outputs are sampled 1 time unit after edges.
// Expected values are hand-computed constants.
module tb_flash_write_unlock;

    logic        m2;
    logic        reset_n;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        prg_write_enabled;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_out_enabled;
    logic [1:0]  lock_state;

    int total;
    int bad;

    flash_write_unlock #(
        .KEY0         (8'hC0),
        .KEY1         (8'h01),
        .KEY2         (8'h6E),
        .KEY_TIMEOUT  (64),
        .IDLE_TIMEOUT (100),
        .WRITE_BUDGET (4)
    ) dut (
        .m2                   (m2),
        .reset_n              (reset_n),
        .romsel               (romsel),
        .cpu_rw_in            (cpu_rw_in),
        .cpu_addr_in          (cpu_addr_in),
        .cpu_data_in          (cpu_data_in),
        .prg_write_enabled    (prg_write_enabled),
        .cpu_data_out         (cpu_data_out),
        .cpu_data_out_enabled (cpu_data_out_enabled),
        .lock_state           (lock_state)
    );

    initial begin
        m2 = 1'b0;
        forever #5 m2 = ~m2;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One CPU cycle: drive at rising M2, let the falling edge commit, settle
    task automatic bus_cyc(input logic rs, input logic rw, input logic [14:0] a,
                           input logic [7:0] d);
        @(posedge m2);
        romsel      = rs;
        cpu_rw_in   = rw;
        cpu_addr_in = a;
        cpu_data_in = d;
        @(negedge m2);
        #1;
    endtask

    task automatic key_wr(input logic [7:0] d);
        bus_cyc(1'b1, 1'b0, 15'h5FF0, d);
    endtask

    task automatic rom_wr();
        bus_cyc(1'b0, 1'b0, 15'h0000, 8'hA5);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cyc(1'b1, 1'b1, 15'h0000, 8'h00);
    endtask

    // Status read: checks readback while M2 is high, then the enable drop with M2 low
    task automatic read_stat(input string tag, input logic [7:0] exp);
        @(posedge m2);
        romsel      = 1'b1;
        cpu_rw_in   = 1'b1;
        cpu_addr_in = 15'h5FF1;
        #1;
        chk({tag, "_oe"}, {7'd0, cpu_data_out_enabled}, 8'h01);
        chk(tag, cpu_data_out, exp);
        @(negedge m2);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        romsel      = 1'b1;
        cpu_rw_in   = 1'b1;
        cpu_addr_in = 15'h0000;
        cpu_data_in = 8'h00;
        #12;
        chk("rst_state", {6'd0, lock_state}, 8'h00);
        chk("rst_pwe", {7'd0, prg_write_enabled}, 8'h00);
        chk("rst_oe", {7'd0, cpu_data_out_enabled}, 8'h00);
        #3 reset_n = 1'b1;

        read_stat("rst_stat", 8'h00);
        chk("oe_m2_low", {7'd0, cpu_data_out_enabled}, 8'h00);

        // ROM write while locked: no enable, violation 1
        rom_wr();
        chk("viol_pwe", {7'd0, prg_write_enabled}, 8'h00);
        read_stat("viol_stat", 8'h01);

        // Unlock sequence
        key_wr(8'hC0);
        chk("k0_state", {6'd0, lock_state}, 8'h01);
        key_wr(8'h01);
        chk("k1_state", {6'd0, lock_state}, 8'h02);
        chk("k1_pwe", {7'd0, prg_write_enabled}, 8'h00);
        key_wr(8'h6E);
        chk("k2_state", {6'd0, lock_state}, 8'h03);
        chk("k2_pwe", {7'd0, prg_write_enabled}, 8'h01);
        read_stat("unl_stat", 8'hC1);

        // Budget of 4: the 4th write still sees enable, then relock
        for (int i = 1; i <= 3; i++) begin
            rom_wr();
            chk($sformatf("bud%0d_pwe", i), {7'd0, prg_write_enabled}, 8'h01);
            chk($sformatf("bud%0d_state", i), {6'd0, lock_state}, 8'h03);
        end
        rom_wr();
        chk("bud4_pwe", {7'd0, prg_write_enabled}, 8'h00);
        chk("bud4_state", {6'd0, lock_state}, 8'h00);
        read_stat("bud_stat", 8'h21);
        rom_wr();
        read_stat("bud5_stat", 8'h22);
        bus_cyc(1'b1, 1'b0, 15'h5FF1, 8'h5A);
        read_stat("clr_stat", 8'h20);

        // Key timeout: 63 idle cycles survive, the 64th relocks
        key_wr(8'hC0);
        idle(63);
        chk("kto63_state", {6'd0, lock_state}, 8'h01);
        idle(1);
        chk("kto64_state", {6'd0, lock_state}, 8'h00);
        key_wr(8'h01);
        chk("kto_late_state", {6'd0, lock_state}, 8'h00);

        // Wrong third key, then ROM write mid-sequence
        key_wr(8'hC0);
        key_wr(8'h01);
        key_wr(8'h55);
        chk("badkey_state", {6'd0, lock_state}, 8'h00);
        key_wr(8'hC0);
        key_wr(8'h01);
        rom_wr();
        chk("abort_state", {6'd0, lock_state}, 8'h00);
        read_stat("abort_stat", 8'h21);

        // Idle timeout of 100; a non-relock key value is ignored but counts as idle
        key_wr(8'hC0);
        key_wr(8'h01);
        key_wr(8'h6E);
        read_stat("unl2_stat", 8'hC1);
        key_wr(8'h12);
        chk("ign_state", {6'd0, lock_state}, 8'h03);
        idle(97);
        chk("ito99_state", {6'd0, lock_state}, 8'h03);
        idle(1);
        chk("ito100_state", {6'd0, lock_state}, 8'h00);
        chk("ito100_pwe", {7'd0, prg_write_enabled}, 8'h00);

        // Asynchronous reset while unlocked, mid-cycle with M2 high
        key_wr(8'hC0);
        key_wr(8'h01);
        key_wr(8'h6E);
        @(posedge m2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pwe", {7'd0, prg_write_enabled}, 8'h00);
        chk("arst_state", {6'd0, lock_state}, 8'h00);
        @(negedge m2);
        #2 reset_n = 1'b1;

        // Re-unlock, explicit relock, then violation and status-write clear
        key_wr(8'hC0);
        key_wr(8'h01);
        key_wr(8'h6E);
        chk("reunl_state", {6'd0, lock_state}, 8'h03);
        key_wr(8'h00);
        chk("relock_state", {6'd0, lock_state}, 8'h00);
        chk("relock_pwe", {7'd0, prg_write_enabled}, 8'h00);
        rom_wr();
        read_stat("post_stat", 8'h01);
        bus_cyc(1'b1, 1'b0, 15'h5FF1, 8'hFF);
        read_stat("final_stat", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
